// File: rtl/xilly_fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// An owner keeps the port until its burst ends, it pauses, or it reaches MAX_BURST words.
module xilly_fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [31:0]               word_count
);

    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam logic [7:0]        BURST_CAP = 8'(MAX_BURST);
    localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic [31:0]        word_count_q, word_count_d;

    logic               owner_valid;
    logic               owner_last;
    logic               xfer;
    logic [7:0]         burst_cnt_inc;
    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;

    // Owner-side view of the request bus, selected by the one-hot grant
    always_comb begin
        owner_valid = |(req_valid & grant_q);
        owner_last  = |(req_last & grant_q);
        fifo_din    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                fifo_din = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset forces the handshake quiet even before the state register clears
    always_comb begin
        xfer       = (state_q == S_BURST) && owner_valid && !fifo_full && rst;
        fifo_wr_en = xfer;
        req_ready  = '0;
        if ((state_q == S_BURST) && !fifo_full && rst) begin
            req_ready = grant_q;
        end
    end

    // Round-robin search starting just above the previous owner
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(last_ptr_q) + 1 + k) % NUM_REQ);
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign burst_cnt_inc = burst_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_ptr_d   = last_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        word_count_d = word_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d     = S_BURST;
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    last_ptr_d  = pick_idx;
                    burst_cnt_d = 8'd0;
                end
            end
            S_BURST: begin
                // A full FIFO freezes the burst entirely: no transfer, no release
                if (!fifo_full) begin
                    if (!owner_valid) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end else begin
                        burst_cnt_d  = burst_cnt_inc;
                        word_count_d = word_count_q + 32'd1;
                        if (owner_last || (burst_cnt_inc == BURST_CAP)) begin
                            state_d = S_IDLE;
                            grant_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_ptr_q   <= PTR_RST;
            burst_cnt_q  <= 8'd0;
            word_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_ptr_q   <= last_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            word_count_q <= word_count_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == S_BURST);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_xilly_fifo_wr_arbiter.sv
// Directed bench for xilly_fifo_wr_arbiter: scripted producers, captured FIFO writes.
module tb_xilly_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   fifo_din;
    logic            fifo_wr_en;
    logic            fifo_full;
    logic [NR-1:0]   grant;
    logic            busy;
    logic [31:0]     word_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pd [NR][0:31];
    bit          pl [NR][0:31];
    int          head [NR];
    int          tail [NR];
    bit [NR-1:0] en;
    logic [31:0] obs [0:63];
    int          obs_n;

    always #5 clk = ~clk;

    xilly_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .grant(grant), .busy(busy), .word_count(word_count)
    );

    function automatic void drive();
        for (int i = 0; i < NR; i++) begin
            if (en[i] && head[i] < tail[i]) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = pl[i][head[i]];
                req_data[i*DW +: DW] = pd[i][head[i]];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endfunction

    function automatic void push(input int r, input logic [31:0] d, input bit l);
        pd[r][tail[r]] = d;
        pl[r][tail[r]] = l;
        tail[r]++;
    endfunction

    function automatic void clear_q();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endfunction

    // One clock: sample handshakes mid-cycle, advance producers after the edge
    task automatic tick();
        bit [NR-1:0] hs;
        logic        w;
        logic [31:0] d;
        #1;
        hs = req_valid & req_ready;
        w  = fifo_wr_en;
        d  = fifo_din;
        @(posedge clk);
        #1;
        if (w === 1'b1 && obs_n < 64) begin
            obs[obs_n] = d;
            obs_n++;
        end
        for (int i = 0; i < NR; i++) begin
            if (hs[i] === 1'b1) head[i]++;
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = '0;
        fifo_full = 1'b0;
        clear_q();
        drive();
        tick();
        rst = 1'b1;
        tick();
        obs_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fifo_full = 1'b0;
        obs_n = 0;
        clear_q();
        push(0, 32'h11, 1'b1);
        en = 4'b0001;
        drive();
        tick();
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (word_count !== 32'd0) begin failures++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        en = '0;
        clear_q();
        drive();
        rst = 1'b1;
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_idle_grant: got %b want 0000", grant); end
    endtask

    task automatic test_single();
        do_reset();
        push(1, 32'hA0, 1'b0);
        push(1, 32'hA1, 1'b0);
        push(1, 32'hA2, 1'b1);
        en = 4'b0010;
        drive();
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_pre_grant: got %b want 0000", grant); end
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL single_pre_wr: got %b want 0", fifo_wr_en); end
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant: got %b want 0010", grant); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL single_wr%0d: got %b want 1", k, fifo_wr_en); end
            checks++; if (fifo_din !== 32'hA0 + k) begin failures++; $display("FAIL single_din%0d: got %h want %h", k, fifo_din, 32'hA0 + k); end
            tick();
        end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_release: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", busy); end
        checks++; if (word_count !== 32'd3) begin failures++; $display("FAIL single_count: got %0d want 3", word_count); end
        checks++; if (obs_n !== 3) begin failures++; $display("FAIL single_fifo_n: got %0d want 3", obs_n); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (obs[k] !== 32'hA0 + k) begin failures++; $display("FAIL single_fifo%0d: got %h want %h", k, obs[k], 32'hA0 + k); end
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            push(i, 32'h100 * i + 0, 1'b0);
            push(i, 32'h100 * i + 1, 1'b1);
            push(i, 32'h100 * i + 2, 1'b0);
            push(i, 32'h100 * i + 3, 1'b1);
        end
        en = 4'b1111;
        drive();
        tick();
        for (int b = 0; b < 5; b++) begin
            checks++; if (grant !== (4'b0001 << order[b])) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", b, grant, 4'b0001 << order[b]); end
            checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL rr_wr_a%0d: got %b want 1", b, fifo_wr_en); end
            tick();
            checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL rr_wr_b%0d: got %b want 1", b, fifo_wr_en); end
            tick();
            checks++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rr_gap%0d: got grant %b wr %b want 0000 0", b, grant, fifo_wr_en); end
            if (b < 4) tick();
        end
        checks++; if (word_count !== 32'd10) begin failures++; $display("FAIL rr_count: got %0d want 10", word_count); end
        for (int j = 0; j < 10; j++) begin
            e = 32'h100 * order[j/2] + ((j/2 == 4) ? 2 : 0) + (j % 2);
            checks++; if (obs[j] !== e) begin failures++; $display("FAIL rr_fifo%0d: got %h want %h", j, obs[j], e); end
        end
        en = '0;
        drive();
    endtask

    task automatic test_burst_cap();
        int n;
        do_reset();
        for (int k = 0; k < 20; k++) push(2, 32'h2000 + k, 1'b0);
        en = 4'b0100;
        drive();
        tick();
        n = 0;
        for (int k = 0; k < 16; k++) begin
            if (fifo_wr_en === 1'b1 && grant === 4'b0100) n++;
            tick();
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL cap_first_words: got %0d want 16", n); end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL cap_release: got grant %b busy %b want 0000 0", grant, busy); end
        tick();
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL cap_regrant: got %b want 0100", grant); end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (fifo_wr_en === 1'b1) n++;
            tick();
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL cap_rest_words: got %0d want 4", n); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL cap_end_grant: got %b want 0000", grant); end
        checks++; if (word_count !== 32'd20) begin failures++; $display("FAIL cap_count: got %0d want 20", word_count); end
        n = 0;
        for (int k = 0; k < 20; k++) if (obs[k] !== 32'h2000 + k) n++;
        checks++; if (n !== 0 || obs_n !== 20) begin failures++; $display("FAIL cap_fifo: got %0d bad of %0d want 0 of 20", n, obs_n); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 4; k++) push(0, 32'hB0 + k, k == 3);
        en = 4'b0001;
        drive();
        tick();
        tick();
        tick();
        fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin failures++; $display("FAIL bp_stall%0d: got ready %b wr %b want 0000 0", k, req_ready, fifo_wr_en); end
            checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL bp_grant%0d: got %b want 0001", k, grant); end
            tick();
        end
        fifo_full = 1'b0;
        #1;
        checks++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0001) begin failures++; $display("FAIL bp_resume: got wr %b ready %b want 1 0001", fifo_wr_en, req_ready); end
        checks++; if (fifo_din !== 32'hB2) begin failures++; $display("FAIL bp_din: got %h want b2", fifo_din); end
        tick();
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL bp_release: got %b want 0000", grant); end
        checks++; if (word_count !== 32'd4 || obs_n !== 4) begin failures++; $display("FAIL bp_count: got %0d/%0d want 4/4", word_count, obs_n); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (obs[k] !== 32'hB0 + k) begin failures++; $display("FAIL bp_fifo%0d: got %h want %h", k, obs[k], 32'hB0 + k); end
        end
    endtask

    task automatic test_pause();
        do_reset();
        for (int k = 0; k < 4; k++) push(3, 32'h30 + k, k == 3);
        push(0, 32'hC0, 1'b0);
        push(0, 32'hC1, 1'b1);
        en = 4'b1000;
        drive();
        tick();
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL pause_grant3: got %b want 1000", grant); end
        tick();
        tick();
        en = 4'b0001;
        drive();
        #1;
        checks++; if (fifo_wr_en !== 1'b0 || grant !== 4'b1000) begin failures++; $display("FAIL pause_hold: got wr %b grant %b want 0 1000", fifo_wr_en, grant); end
        tick();
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL pause_release: got grant %b busy %b want 0000 0", grant, busy); end
        en = 4'b1001;
        drive();
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL pause_next: got %b want 0001", grant); end
        checks++; if (word_count !== 32'd2 || obs[0] !== 32'h30 || obs[1] !== 32'h31) begin failures++; $display("FAIL pause_words: got %0d %h %h want 2 30 31", word_count, obs[0], obs[1]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 6; k++) push(1, 32'h50 + k, k == 5);
        en = 4'b0010;
        drive();
        tick();
        tick();
        tick();
        checks++; if (word_count !== 32'd2) begin failures++; $display("FAIL mid_pre_count: got %0d want 2", word_count); end
        rst = 1'b0;
        #1;
        checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL mid_gate: got wr %b ready %b want 0 0000", fifo_wr_en, req_ready); end
        tick();
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL mid_state: got grant %b busy %b want 0000 0", grant, busy); end
        checks++; if (word_count !== 32'd0) begin failures++; $display("FAIL mid_count: got %0d want 0", word_count); end
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_wr: got %b want 0", fifo_wr_en); end
        rst = 1'b1;
        push(0, 32'hD0, 1'b1);
        push(2, 32'hE0, 1'b1);
        en = 4'b0101;
        drive();
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL mid_restart: got %b want 0001", grant); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        en        = '0;
        fifo_full = 1'b0;
        rst       = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_pause();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
